gdp_sequencer: RTL
==================

Name: gdp_sequencer

Overview:
- Controller that streams one observation vector through the gdp log-probability pipeline for every Gaussian in a model.
- Generates parameter/observation memory addresses and aligns the returned data with gdp first_calc/last_calc.
- Collects each ln_p result and reports per-Gaussian scores plus the best-scoring Gaussian index.
- Sits between the observation/parameter RAMs and one gdp instance; a higher-level decoder issues start and reads done.

Parameters:
NUM_DIMS, 8, feature dimensions per Gaussian (>=1)
NUM_GAUSS, 16, Gaussians per model (>=1)
DIM_W, $clog2(NUM_DIMS), dimension index width (min 1)
GAUSS_W, $clog2(NUM_GAUSS), Gaussian index width (min 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin a pass; sampled only in IDLE
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after last score captured
obs_addr  out  DIM_W  observation RAM address
obs_data  in  16  x value, valid 1 cycle after obs_addr
prm_addr  out  GAUSS_W+DIM_W  {gauss,dim} address for mean/omega RAM
mean_data  in  16  mean, 1-cycle read latency
omega_data  in  16  omega, 1-cycle read latency
k_addr  out  GAUSS_W  constant-term RAM address
k_data  in  16  k, 1-cycle read latency
gdp_x, gdp_mean, gdp_omega, gdp_k  out  16 each  registered drive to gdp
gdp_first_calc, gdp_last_calc  out  1  registered drive to gdp
gdp_ln_p  in  16  gdp result
gdp_data_ready  in  1  gdp result strobe
score_valid  out  1  one-cycle pulse per captured score
score  out  16  captured ln_p
score_idx  out  GAUSS_W  Gaussian index of score
best_score  out  16  running maximum (signed)
best_idx  out  GAUSS_W  index of best_score

Behaviour:
- Clock is clk. Reset is synchronous and active-high, named reset. All state updates on the posedge of clk.
- Reset values: all outputs 0, state IDLE, counters 0. The same reset must drive the attached gdp.
- Reset asserted mid-pass aborts the pass with no done pulse and returns all outputs to their reset values on the next edge.
- States:
  - IDLE: start=1 -> ISSUE. Clear best_score to 0x8000 (most negative), best_idx=0, counters=0; busy=1 from the next cycle.
  - ISSUE:
    - One address per cycle, dim incrementing fastest; gauss increments when dim wraps from NUM_DIMS-1 to 0.
    - After issuing (NUM_GAUSS-1, NUM_DIMS-1) -> DRAIN.
    - No bubbles between Gaussians.
  - DRAIN: wait until the result counter reaches NUM_GAUSS -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- start while busy is ignored.
- Alignment:
  - Tag first=(dim==0), last=(dim==NUM_DIMS-1) and valid=1 at issue; delay the tag one cycle to match RAM latency.
  - The gdp_* registers load on the delayed valid, so RAM data and tags reach gdp together.
  - When the delayed valid is low, gdp_first_calc/gdp_last_calc are 0 and the data registers hold their values.
  - NUM_DIMS=1: first and last are both asserted on the same beat.
- Result capture:
  - Results are counted from gdp_data_ready; the controller never depends on gdp latency.
  - On each gdp_data_ready: score<=gdp_ln_p, score_idx<=result counter, score_valid=1 next cycle, counter++.
  - best update is a strict signed greater-than, so ties keep the lower index.
  - The update for the final result completes on the cycle before done.
- gdp_data_ready outside a pass (IDLE) is ignored.
- Outputs score/score_idx/best_* hold after done until the next start.

Decomposition:
- Shared package gdp_pkg:
  - typedef num (logic signed [15:0]).
  - DECIMAL_POSITION=11.
  - NUM_MIN=16'sh8000.
  - Enum seq_state_t {IDLE, ISSUE, DRAIN, DONE}.
- One natural sub-module, gdp_addr_gen: the dim/gauss nested counter producing addresses, first/last tags and issue-complete flag.
- The FSM, alignment stage and score tracker stay in gdp_sequencer.

Test Plan:
- NUM_DIMS=2, NUM_GAUSS=4, obs==mean for all dims, k={0x0100,0x0300,0x0300,0x0080}, real gdp -> scores 0x0100,0x0300,0x0300,0x0080 with idx 0..3 in order; best_score=0x0300, best_idx=1; done exactly once, at most NUM_GAUSS*NUM_DIMS+8 cycles after start accepted.
- Address trace, same config -> prm_addr sequence 0,1,2,...,7 on consecutive cycles; gdp_first_calc on beats 0,2,4,6; gdp_last_calc on beats 1,3,5,7; no gaps.
- NUM_DIMS=1, NUM_GAUSS=3, k={0xF000,0xE000,0xF800} (all negative) -> best_score=0xF800, best_idx=2; first_calc and last_calc asserted on every beat.
- start pulsed again at cycles 3 and 10 of a pass -> ignored; exactly one pass and one done pulse; second start after done runs a fresh pass with best reset.
- reset asserted for 1 cycle during ISSUE -> next cycle busy=0, score_valid=0, all addresses 0, no done pulse; subsequent start completes normally.
- Stub gdp with data_ready delay randomised 3–20 cycles -> all NUM_GAUSS scores captured in order; done only after the last one.

Source files
------------

// File: rtl/gdp_pkg.sv
// Shared types and constants for the gdp log-probability datapath and its sequencer.
package gdp_pkg;

    // Q4.11 signed fixed-point value used throughout the gdp datapath
    typedef logic signed [15:0] num;

    localparam int DECIMAL_POSITION = 11;
    localparam num NUM_MIN          = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Strict signed greater-than: ties keep the earlier (lower-index) score
    function automatic logic num_gt(input num a, input num b);
        return (a > b) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/gdp_addr_gen.sv
// Nested dim/gauss counter: dim runs fastest, gauss advances when dim wraps.
// Counters are registers and drive the RAM addresses directly.
module gdp_addr_gen
    import gdp_pkg::*;
#(
    parameter int NUM_DIMS  = 8,
    parameter int NUM_GAUSS = 16,
    parameter int DIM_W     = (NUM_DIMS  > 1) ? $clog2(NUM_DIMS)  : 1,
    parameter int GAUSS_W   = (NUM_GAUSS > 1) ? $clog2(NUM_GAUSS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_en,
    output logic [DIM_W-1:0]   o_dim,
    output logic [GAUSS_W-1:0] o_gauss,
    output logic               o_first,
    output logic               o_last,
    output logic               o_issue_last
);

    localparam logic [DIM_W-1:0]   DIM_LAST   = DIM_W'(NUM_DIMS - 1);
    localparam logic [GAUSS_W-1:0] GAUSS_LAST = GAUSS_W'(NUM_GAUSS - 1);

    logic [DIM_W-1:0]   r_dim;
    logic [GAUSS_W-1:0] r_gauss;

    // Advance one address per enabled cycle; the final address wraps both counters to 0
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_dim   <= {DIM_W{1'b0}};
            r_gauss <= {GAUSS_W{1'b0}};
        end else if (i_en) begin
            if (r_dim == DIM_LAST) begin
                r_dim <= {DIM_W{1'b0}};
                if (r_gauss == GAUSS_LAST) begin
                    r_gauss <= {GAUSS_W{1'b0}};
                end else begin
                    r_gauss <= r_gauss + GAUSS_W'(1);
                end
            end else begin
                r_dim <= r_dim + DIM_W'(1);
            end
        end
    end

    assign o_dim        = r_dim;
    assign o_gauss      = r_gauss;
    assign o_first      = (r_dim == {DIM_W{1'b0}});
    assign o_last       = (r_dim == DIM_LAST);
    assign o_issue_last = (r_dim == DIM_LAST) && (r_gauss == GAUSS_LAST);

endmodule

// File: rtl/gdp_sequencer.sv
// Streams one observation vector through the gdp pipeline for every Gaussian,
// aligns RAM data with first/last tags and tracks per-Gaussian and best scores.
module gdp_sequencer
    import gdp_pkg::*;
#(
    parameter int NUM_DIMS  = 8,
    parameter int NUM_GAUSS = 16,
    parameter int DIM_W     = (NUM_DIMS  > 1) ? $clog2(NUM_DIMS)  : 1,
    parameter int GAUSS_W   = (NUM_GAUSS > 1) ? $clog2(NUM_GAUSS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [DIM_W-1:0]         obs_addr,
    input  logic [15:0]              obs_data,
    output logic [GAUSS_W+DIM_W-1:0] prm_addr,
    input  logic [15:0]              mean_data,
    input  logic [15:0]              omega_data,
    output logic [GAUSS_W-1:0]       k_addr,
    input  logic [15:0]              k_data,
    output logic [15:0]              gdp_x,
    output logic [15:0]              gdp_mean,
    output logic [15:0]              gdp_omega,
    output logic [15:0]              gdp_k,
    output logic                     gdp_first_calc,
    output logic                     gdp_last_calc,
    input  logic [15:0]              gdp_ln_p,
    input  logic                     gdp_data_ready,
    output logic                     score_valid,
    output logic [15:0]              score,
    output logic [GAUSS_W-1:0]       score_idx,
    output logic [15:0]              best_score,
    output logic [GAUSS_W-1:0]       best_idx
);

    // Result counter is one bit wider so it can reach NUM_GAUSS
    localparam logic [GAUSS_W:0] RES_ALL = (GAUSS_W+1)'(NUM_GAUSS);

    seq_state_t         r_state;
    logic [GAUSS_W:0]   r_res_cnt;
    logic               r_tag_valid;
    logic               r_tag_first;
    logic               r_tag_last;

    logic [DIM_W-1:0]   w_dim;
    logic [GAUSS_W-1:0] w_gauss;
    logic               w_first;
    logic               w_last;
    logic               w_issue_last;
    logic               w_start_acc;
    logic               w_issuing;
    logic               w_capture;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_issuing   = (r_state == ISSUE);
    // Results only count inside a pass and never beyond the expected number
    assign w_capture   = gdp_data_ready && (r_state == ISSUE || r_state == DRAIN) &&
                         (r_res_cnt != RES_ALL);

    gdp_addr_gen #(
        .NUM_DIMS  (NUM_DIMS),
        .NUM_GAUSS (NUM_GAUSS),
        .DIM_W     (DIM_W),
        .GAUSS_W   (GAUSS_W)
    ) u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_start_acc),
        .i_en         (w_issuing),
        .o_dim        (w_dim),
        .o_gauss      (w_gauss),
        .o_first      (w_first),
        .o_last       (w_last),
        .o_issue_last (w_issue_last)
    );

    assign obs_addr = w_dim;
    assign prm_addr = {w_gauss, w_dim};
    assign k_addr   = w_gauss;

    // Delay issue tags one cycle to meet RAM data, then register data+tags toward gdp together
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_valid    <= 1'b0;
            r_tag_first    <= 1'b0;
            r_tag_last     <= 1'b0;
            gdp_x          <= 16'h0000;
            gdp_mean       <= 16'h0000;
            gdp_omega      <= 16'h0000;
            gdp_k          <= 16'h0000;
            gdp_first_calc <= 1'b0;
            gdp_last_calc  <= 1'b0;
        end else begin
            r_tag_valid <= w_issuing;
            r_tag_first <= w_issuing && w_first;
            r_tag_last  <= w_issuing && w_last;
            if (r_tag_valid) begin
                gdp_x          <= obs_data;
                gdp_mean       <= mean_data;
                gdp_omega      <= omega_data;
                gdp_k          <= k_data;
                gdp_first_calc <= r_tag_first;
                gdp_last_calc  <= r_tag_last;
            end else begin
                gdp_first_calc <= 1'b0;
                gdp_last_calc  <= 1'b0;
            end
        end
    end

    // Pass FSM plus score capture and running signed maximum
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_res_cnt   <= {(GAUSS_W+1){1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            score_valid <= 1'b0;
            score       <= 16'h0000;
            score_idx   <= {GAUSS_W{1'b0}};
            best_score  <= 16'h0000;
            best_idx    <= {GAUSS_W{1'b0}};
        end else begin
            score_valid <= 1'b0;
            done        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= ISSUE;
                        busy       <= 1'b1;
                        best_score <= NUM_MIN;
                        best_idx   <= {GAUSS_W{1'b0}};
                        r_res_cnt  <= {(GAUSS_W+1){1'b0}};
                    end
                end
                ISSUE: begin
                    if (w_issue_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_res_cnt == RES_ALL) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            if (w_capture) begin
                score       <= gdp_ln_p;
                score_idx   <= r_res_cnt[GAUSS_W-1:0];
                score_valid <= 1'b1;
                r_res_cnt   <= r_res_cnt + (GAUSS_W+1)'(1);
                if (num_gt(gdp_ln_p, best_score)) begin
                    best_score <= gdp_ln_p;
                    best_idx   <= r_res_cnt[GAUSS_W-1:0];
                end
            end
        end
    end

endmodule
